// File: rtl/alu_seq_responder.sv
// alu_seq_responder: digit-serial ALU behind valid/ready request and response channels.
// Operands are consumed DIGIT bits per EXEC cycle, LSB first. The result shifts into
// result_q from the top, so after N = WIDTH/DIGIT cycles every digit is in its final place.
// Optional feature macro: ALU_SEQ_FAST_LOGIC_EN. When it is defined, the bitwise commands
// finish in a single EXEC cycle. Flags and results are the same in both builds.
module alu_seq_responder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = DIGIT + 1;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic             isArith, isSub, isSlt, lastDigit;
  logic [DIGIT-1:0] aDig, bDig, bEff, logicDig, digitOut;
  logic [DW-1:0]    digitSum;
  logic             digitOvf, sltBit;

  // Per-digit datapath: one adder slice plus the bitwise functions on the lowest digit
  always_comb begin
    isSub     = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    isSlt     = (cmd_q == CMD_SLT);
    isArith   = (cmd_q == CMD_ADD) || isSub;
    lastDigit = (cnt_q == CW'(N - 1));
    aDig      = a_q[DIGIT-1:0];
    bDig      = b_q[DIGIT-1:0];
    bEff      = isSub ? ~bDig : bDig;
    digitSum  = {1'b0, aDig} + {1'b0, bEff} + DW'(carry_q);
    digitOvf  = (aDig[DIGIT-1] == bEff[DIGIT-1]) && (digitSum[DIGIT-1] != aDig[DIGIT-1]);
    sltBit    = digitSum[DIGIT-1] ^ digitOvf;
    case (cmd_q)
      CMD_XOR:  logicDig = aDig ^ bDig;
      CMD_AND:  logicDig = aDig & bDig;
      CMD_NAND: logicDig = ~(aDig & bDig);
      CMD_NOR:  logicDig = ~(aDig | bDig);
      CMD_OR:   logicDig = aDig | bDig;
      default:  logicDig = '0;
    endcase
    digitOut = isArith ? digitSum[DIGIT-1:0] : logicDig;
  end

  // Control FSM: next state, next register values and handshake outputs
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = EXEC;
          a_d     = operandA;
          b_d     = operandB;
          cmd_d   = command;
          cnt_d   = '0;
          carry_d = (command == CMD_SUB) || (command == CMD_SLT);
        end
      end
      EXEC: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        cnt_d    = cnt_q + CW'(1);
        carry_d  = digitSum[DIGIT];
        result_d = (result_q >> DIGIT) | (WIDTH'(digitOut) << (WIDTH - DIGIT));
        if (lastDigit) begin
          state_d    = DONE;
          carryout_d = isArith && !isSlt && digitSum[DIGIT];
          overflow_d = isArith && !isSlt && digitOvf;
          if (isSlt) begin
            result_d = WIDTH'(sltBit);
          end
        end
`ifdef ALU_SEQ_FAST_LOGIC_EN
        if (!isArith) begin
          state_d    = DONE;
          carryout_d = 1'b0;
          overflow_d = 1'b0;
          case (cmd_q)
            CMD_XOR:  result_d = a_q ^ b_q;
            CMD_AND:  result_d = a_q & b_q;
            CMD_NAND: result_d = ~(a_q & b_q);
            CMD_NOR:  result_d = ~(a_q | b_q);
            default:  result_d = a_q | b_q;
          endcase
        end
`endif
        if (state_d == DONE) begin
          zero_d = (result_d == '0);
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign carryout = carryout_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder: drives requests (directed and random) into alu_seq_responder.
// Every accepted request pushes its expected response into a queue. A monitor then checks
// the queue head on every cycle in which resp_valid is high.
module tb_alu_seq_responder;

  localparam int WIDTH = 32;
  localparam int DIGIT = 1;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] operandA = '0;
  logic [WIDTH-1:0] operandB = '0;
  logic [2:0]       command = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             overflow;

  alu_seq_responder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .operandA(operandA), .operandB(operandB), .command(command),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .carryout(carryout), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        co;
    logic        z;
    logic        ov;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  int     stall = 0;
  longint cycle = 0;
  logic   prevValid = 1'b0;

  // Free-running cycle count, used to measure response latency
  always @(posedge clk) cycle <= cycle + 1;

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference ALU: whole-word arithmetic, signed ranges decide overflow
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb2 = longint'($signed(b));
    longint s;
    logic [32:0] u;
    e.co = 1'b0;
    e.ov = 1'b0;
    e.r  = '0;
    case (c)
      3'b000: begin
        u = {1'b0, a} + {1'b0, b};
        e.r = u[31:0];
        e.co = u[32];
        s = sa + sb2;
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b001: begin
        e.r = a - b;
        e.co = (a >= b);
        s = sa - sb2;
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b010: e.r = a ^ b;
      3'b011: e.r = (sa < sb2) ? 32'd1 : 32'd0;
      3'b100: e.r = a & b;
      3'b101: e.r = ~(a & b);
      3'b110: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    e.z = (e.r == 32'd0);
    e.lat = N;
`ifdef ALU_SEQ_FAST_LOGIC_EN
    if (c != 3'b000 && c != 3'b001 && c != 3'b011) e.lat = 1;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Present a request, wait (bounded) for acceptance, then scramble the inputs
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   waitCycles = 0;
    e = model(c, a, b);
    @(negedge clk);
    req_valid = 1'b1;
    command   = c;
    operandA  = a;
    operandB  = b;
    while (!req_ready && waitCycles < 500) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.acc = cycle + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    operandA  = $urandom;
    operandB  = $urandom;
    command   = 3'($urandom_range(0, 7));
  endtask

  // Wait (bounded) until every expected response has been consumed
  task automatic waitDrain();
    int k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Directed values that stress carries, signs and the zero flag
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: check the queue head while a response is shown, then handshake it with random backpressure
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 64'd1, 64'd0);
          resp_ready = 1'b1;
        end else begin
          e = sb[0];
          if (!prevValid) checkOutput("latency", 64'(cycle - e.acc), 64'(e.lat));
          checkOutput("result", 64'(result), 64'(e.r));
          checkOutput("carryout", 64'(carryout), 64'(e.co));
          checkOutput("zero", 64'(zero), 64'(e.z));
          checkOutput("overflow", 64'(overflow), 64'(e.ov));
          checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
          if (stall > 0) begin
            resp_ready = 1'b0;
            stall--;
          end else begin
            resp_ready = ($urandom_range(0, 3) != 0);
          end
          if (resp_ready) void'(sb.pop_front());
        end
      end else begin
        resp_ready = 1'b0;
      end
    end
    prevValid = resp_valid;
  end

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, directed cases, random traffic, mid-operation reset
  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd0);
    checkOutput("reset_flags", 64'({carryout, overflow}), 64'd0);

    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(3'b001, 32'd100, 32'd300);
    applyStimulus(3'b001, 32'h8000_0000, 32'h0000_0001);
    applyStimulus(3'b011, 32'd100, 32'd200);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(3'b011, 32'd200, 32'd100);
    waitDrain();

    stall = 5;
    applyStimulus(3'b101, 32'h0000_011C, 32'h0000_01FF);
    waitDrain();

    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
    end
    waitDrain();

    applyStimulus(3'b000, $urandom, $urandom);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_ready", 64'(req_ready), 64'd1);
    checkOutput("abort_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("abort_result", 64'(result), 64'd0);
    repeat (40) @(negedge clk);
    applyStimulus(3'b000, 32'd3, 32'd4);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
